updown_mod_counter: RTL and testbench
=====================================

# updown_mod_counter

Parametrised synchronous up/down modulo counter, successor to the fixed 3-bit down counter. Adds configurable width and modulus, a direction input, synchronous load, a count-enable prescaler and a registered terminal-count pulse. Used as the general-purpose event and timebase counter in the sequential-logic set. With default parameters and `up`=0 it reproduces the 3-bit down-count sequence 7,6,…,0,7.

## Interface
- WIDTH, 3, counter width in bits.
- MOD, 8, modulus; count range 0..MOD-1; 2 ≤ MOD ≤ 2**WIDTH.
- RST_VAL, MOD-1, value of `o` after reset; must be < MOD.
- PRESCALE, 1, number of enabled cycles per count step; ≥ 1.

- c  in  1  clock, rising-edge active.
- r  in  1  reset, synchronous, active-high.
- en  in  1  count enable.
- up  in  1  direction: 1 = increment, 0 = decrement.
- ld  in  1  synchronous load strobe.
- d  in  WIDTH  load value.
- o  out  WIDTH  current count (registered).
- tc  out  1  terminal-count pulse (registered).

## Operation
- Priority per rising edge of `c`: `r` > `ld` > count step > hold.
- `r`=1: `o`←RST_VAL, `tc`←0, prescaler←0. Applies mid-operation and overrides every other input.
- `ld`=1 (with `r`=0): `o`←`d`. If `d` ≥ MOD, `o`←MOD-1 (clamp). Prescaler←0, `tc`←0. Ignores `en`.
- Prescaler: internal counter 0..PRESCALE-1. Advances only when `en`=1. A step tick occurs on an enabled cycle when the prescaler is at PRESCALE-1; the prescaler then returns to 0. With PRESCALE=1, every enabled cycle is a tick.
- Step, on a tick:
  - up=1, `o`<MOD-1: `o`←`o`+1.
  - up=0, `o`>0: `o`←`o`-1.
  - Boundary (up=1 at MOD-1, or up=0 at 0): wrap to 0 or to MOD-1 respectively; saturation variant in Configuration.
- `tc`←1 on a tick that hits a boundary; otherwise `tc`←0. `tc` is never held for more than one cycle unless boundary ticks occur on consecutive cycles.
- `en`=0: `o` and prescaler hold; `tc`←0.
- Changing `up` mid-prescale does not reset the prescaler. Direction is sampled on the tick cycle.
- Arithmetic is on WIDTH bits. Boundary detection compares against MOD-1 and 0. Values ≥ MOD are never produced.

## Timing
- All outputs are registered; no combinational input→output paths.
- Latency is 1 cycle from a sampled input to `o`/`tc`: a load or step sampled at edge N is visible after edge N.
- `tc` is asserted in the same cycle `o` first shows the wrapped (or held) boundary result.
- Simultaneous `ld` and tick: load wins; no step, `tc`=0.
- Simultaneous `r` and anything: reset wins.

## Configuration
- `UPDOWN_CNT_SAT_EN` defined: saturating mode. A boundary tick leaves `o` unchanged (held at MOD-1 counting up, or at 0 counting down) and still pulses `tc` for that tick.
- Not defined (default): wrapping mode as described in Operation.

## Structure
- Shared package `counter_pkg`: direction constants `DIR_UP`=1'b1 and `DIR_DOWN`=1'b0, plus a parameter-legality check function (MOD range, RST_VAL<MOD, PRESCALE≥1) used by all counter blocks.
- One sub-module: `tick_prescaler` (parameter PRESCALE; inputs c, r, en, clr; output tick). `clr` is driven by `ld`. For PRESCALE=1, `tick` equals `en`.
- Counter, boundary detection, clamp and `tc` register live in `updown_mod_counter`.

## Test plan
- Defaults, r=1 for 2 cycles then en=1, up=0 -> `o` = 7,6,5,4,3,2,1,0,7; `tc`=1 only in the cycle `o` shows 7 after 0.
- WIDTH=4, MOD=10, up=1, en=1 from reset with RST_VAL=0 -> `o` = 0..9,0; `tc`=1 with the 0 after 9; `o` never reaches 10–15.
- WIDTH=4, MOD=10: ld=1, d=13 -> `o`=9 next cycle. Then ld=1 and en=1 on the same cycle with d=3 -> `o`=3, no step, `tc`=0.
- PRESCALE=3, MOD=8, up=1, from `o`=0 -> `o` increments every 3rd enabled cycle. Drop en for 5 cycles mid-count -> `o` and prescaler phase frozen. Toggle up mid-prescale -> the next step follows the new direction with no phase loss.
- Assert r during a count at `o`=5 -> `o`=RST_VAL and `tc`=0 next cycle; counting resumes with a full PRESCALE interval.
- `UPDOWN_CNT_SAT_EN` defined, defaults, up=0 from `o`=1 -> `o`=0 then holds at 0; `tc`=1 on every enabled tick while held. Switch up=1 -> `o`=1.

Source files
------------

// File: rtl/updown_mod_counter_pkg.sv
// ---------------------------------------------------------------------------
// counter_pkg
// Shared definitions for the counter blocks of the sequential-logic set.
//   DIR_UP / DIR_DOWN : encoding of the direction input (1 = up, 0 = down)
//   params_legal()    : elaboration-time legality check for counter parameters
//                       (2 <= MOD <= 2**WIDTH, RST_VAL < MOD, PRESCALE >= 1)
// ---------------------------------------------------------------------------
package counter_pkg;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   // Returns 1 when the parameter set describes a counter that can be built.
   function automatic bit params_legal(input int width, input int modulus,
                                       input int rst_val, input int prescale);
      longint span;
      span = longint'(1) << width;
      return (width >= 1) && (modulus >= 2) && (longint'(modulus) <= span) &&
             (rst_val >= 0) && (rst_val < modulus) && (prescale >= 1);
   endfunction

endpackage

// File: rtl/updown_mod_counter_if.sv
// ---------------------------------------------------------------------------
// updown_mod_counter_if
// Control/data bundle of the up/down modulo counter.
//   en  : count enable              up : direction (1 = up, 0 = down)
//   ld  : synchronous load strobe   d  : load value (WIDTH bits)
//   o   : current count (WIDTH)     tc : terminal-count pulse
// Modports: master drives the controls and observes o/tc, slave is the counter.
// ---------------------------------------------------------------------------
interface updown_mod_counter_if #(
   parameter int WIDTH = 3
);
   logic             en;
   logic             up;
   logic             ld;
   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] o;
   logic             tc;

   modport master (output en, output up, output ld, output d, input o, input tc);
   modport slave  (input en, input up, input ld, input d, output o, output tc);
endinterface

// File: rtl/updown_mod_counter_tick_prescaler.sv
// ---------------------------------------------------------------------------
// tick_prescaler
// Divides enabled cycles by PRESCALE: tick is high on the enabled cycle in
// which the internal phase counter sits at PRESCALE-1, after which the phase
// returns to 0.  With PRESCALE = 1 the phase never leaves 0, so tick = en.
// Ports:
//   c   : clock, rising edge         r   : synchronous active-high reset
//   en  : advance the phase           clr : synchronous phase clear (load)
//   tick: step strobe (combinational from en and the registered phase)
// ---------------------------------------------------------------------------
module tick_prescaler
   import counter_pkg::*;
#(
   parameter int PRESCALE = 1
) (
   input  logic c,
   input  logic r,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

   logic [CW-1:0] phase_q;

   assign tick = en && (phase_q == LAST);

   // Phase only moves on enabled cycles, so dropping en freezes it in place
   // and a direction change never disturbs it.
   always_ff @(posedge c) begin
      if (r || clr) begin
         phase_q <= '0;
      end else if (en) begin
         phase_q <= (phase_q == LAST) ? '0 : phase_q + CW'(1);
      end
   end

endmodule

// File: rtl/updown_mod_counter.sv
// ---------------------------------------------------------------------------
// updown_mod_counter
// Parametrised synchronous up/down modulo counter with load, prescaled count
// enable and a registered terminal-count pulse.  Defaults with up = 0 give the
// classic 3-bit down count 7,6,...,0,7.
// Parameters: WIDTH, MOD (range 0..MOD-1), RST_VAL, PRESCALE.
// Ports:
//   c   : clock, rising edge
//   r   : synchronous active-high reset (highest priority)
//   bus : updown_mod_counter_if.slave (en, up, ld, d in; o, tc out)
// Build option: define UPDOWN_CNT_SAT_EN for saturating instead of wrapping
// behaviour at the boundaries; tc still pulses on every boundary tick.
// ---------------------------------------------------------------------------
module updown_mod_counter
   import counter_pkg::*;
#(
   parameter int WIDTH    = 3,
   parameter int MOD      = 8,
   parameter int RST_VAL  = MOD - 1,
   parameter int PRESCALE = 1
) (
   input logic                c,
   input logic                r,
   updown_mod_counter_if.slave bus
);

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);
   localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RST_VAL);
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MOD);

   generate
      if (!params_legal(WIDTH, MOD, RST_VAL, PRESCALE)) begin : g_illegal_params
         $error("updown_mod_counter: illegal WIDTH/MOD/RST_VAL/PRESCALE combination");
      end
   endgenerate

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_next;
   logic [WIDTH-1:0] load_val;
   logic             tc_q;
   logic             tick;
   logic             count_up;
   logic             at_boundary;

   tick_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .c    (c),
      .r    (r),
      .en   (bus.en),
      .clr  (bus.ld),
      .tick (tick)
   );

   // Load value is clamped so that a value >= MOD can never appear on o.
   // The compare is one bit wider so MOD = 2**WIDTH is representable.
   always_comb begin
      load_val = bus.d;
      if ({1'b0, bus.d} >= MOD_EXT) begin
         load_val = MAX_VAL;
      end
   end

   // Next count for a tick.  The boundary is MOD-1 going up and 0 going down;
   // there the counter either wraps to the opposite end or holds.
   always_comb begin
      count_up    = (bus.up == DIR_UP);
      at_boundary = count_up ? (cnt_q == MAX_VAL) : (cnt_q == '0);
      cnt_next    = cnt_q;
      if (at_boundary) begin
`ifdef UPDOWN_CNT_SAT_EN
         cnt_next = cnt_q;
`else
         cnt_next = count_up ? '0 : MAX_VAL;
`endif
      end else begin
         cnt_next = count_up ? cnt_q + WIDTH'(1) : cnt_q - WIDTH'(1);
      end
   end

   // Priority: reset, then load, then a prescaled step; tc only survives one
   // cycle because every non-boundary path clears it.
   always_ff @(posedge c) begin
      if (r) begin
         cnt_q <= RST_CNT;
         tc_q  <= 1'b0;
      end else if (bus.ld) begin
         cnt_q <= load_val;
         tc_q  <= 1'b0;
      end else if (tick) begin
         cnt_q <= cnt_next;
         tc_q  <= at_boundary;
      end else begin
         tc_q  <= 1'b0;
      end
   end

   assign bus.o  = cnt_q;
   assign bus.tc = tc_q;

endmodule

// File: tb/tb_updown_mod_counter.sv
// ---------------------------------------------------------------------------
// tb_updown_mod_counter
// Drives three counter configurations side by side (defaults; WIDTH=4 MOD=10
// RST_VAL=0; PRESCALE=3 RST_VAL=0) with directed then random stimulus and
// compares every cycle against an arithmetic reference model, plus literal
// expectations for the directed sequences.
// ---------------------------------------------------------------------------
module tb_updown_mod_counter;
   import counter_pkg::*;

`ifdef UPDOWN_CNT_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic c = 1'b0;
   logic r;

   always #5 c = ~c;

   updown_mod_counter_if #(.WIDTH(3)) if0 ();
   updown_mod_counter_if #(.WIDTH(4)) if1 ();
   updown_mod_counter_if #(.WIDTH(3)) if2 ();

   updown_mod_counter #(.WIDTH(3), .MOD(8)) dut0 (
      .c (c), .r (r), .bus (if0.slave)
   );
   updown_mod_counter #(.WIDTH(4), .MOD(10), .RST_VAL(0)) dut1 (
      .c (c), .r (r), .bus (if1.slave)
   );
   updown_mod_counter #(.WIDTH(3), .MOD(8), .RST_VAL(0), .PRESCALE(3)) dut2 (
      .c (c), .r (r), .bus (if2.slave)
   );

   int mod_a [3] = '{8, 10, 8};
   int rst_a [3] = '{7, 0, 0};
   int ps_a  [3] = '{1, 1, 3};

   int m_o  [3];
   int m_ps [3];
   int m_tc [3];
   bit model_valid = 1'b0;

   int checks = 0;
   int errors = 0;

   int exp0_o [10];
   int exp0_tc[10];
   int exp1_o [10];
   int exp1_tc[10];
   int exp2_o [10];
   int expb_o [4];
   int expb_tc[4];

   task automatic checkOutput(input string name, input logic [31:0] actual, input int expected);
      checks++;
      if (actual !== 32'(expected)) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input int i, input bit en, input bit up, input bit ld, input int d);
      case (i)
         0: begin if0.en = en; if0.up = up; if0.ld = ld; if0.d = 3'(d); end
         1: begin if1.en = en; if1.up = up; if1.ld = ld; if1.d = 4'(d); end
         default: begin if2.en = en; if2.up = up; if2.ld = ld; if2.d = 3'(d); end
      endcase
   endtask

   // Reference model: count value, prescale phase and tc from plain arithmetic.
   function automatic void model_step(input int i, input bit rr, input bit en,
                                      input bit up, input bit ld, input int d);
      if (rr) begin
         m_o[i] = rst_a[i]; m_ps[i] = 0; m_tc[i] = 0;
      end else if (ld) begin
         m_o[i] = (d >= mod_a[i]) ? mod_a[i] - 1 : d; m_ps[i] = 0; m_tc[i] = 0;
      end else if (!en) begin
         m_tc[i] = 0;
      end else if (m_ps[i] < ps_a[i] - 1) begin
         m_ps[i] = m_ps[i] + 1; m_tc[i] = 0;
      end else begin
         m_ps[i] = 0;
         m_tc[i] = up ? int'(m_o[i] == mod_a[i] - 1) : int'(m_o[i] == 0);
         if (!(SAT && m_tc[i] == 1)) begin
            m_o[i] = up ? (m_o[i] + 1) % mod_a[i] : (m_o[i] + mod_a[i] - 1) % mod_a[i];
         end
      end
   endfunction

   always @(posedge c) begin
      if (r === 1'b1) model_valid = 1'b1;
      model_step(0, r, if0.en, if0.up, if0.ld, int'(if0.d));
      model_step(1, r, if1.en, if1.up, if1.ld, int'(if1.d));
      model_step(2, r, if2.en, if2.up, if2.ld, int'(if2.d));
      #1;
      if (model_valid) begin
         checkOutput("model_o0", 32'(if0.o), m_o[0]);
         checkOutput("model_tc0", 32'(if0.tc), m_tc[0]);
         checkOutput("model_o1", 32'(if1.o), m_o[1]);
         checkOutput("model_tc1", 32'(if1.tc), m_tc[1]);
         checkOutput("model_o2", 32'(if2.o), m_o[2]);
         checkOutput("model_tc2", 32'(if2.tc), m_tc[2]);
      end
   end

   initial begin
      r = 1'b1;
      for (int i = 0; i < 3; i++) applyStimulus(i, 1'b0, 1'b0, 1'b0, 0);

`ifdef UPDOWN_CNT_SAT_EN
      exp0_o  = '{6, 5, 4, 3, 2, 1, 0, 0, 0, 0};
      exp0_tc = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
      exp1_o  = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 9};
      expb_o  = '{0, 0, 0, 1};
      expb_tc = '{0, 1, 1, 0};
`else
      exp0_o  = '{6, 5, 4, 3, 2, 1, 0, 7, 6, 5};
      exp0_tc = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
      exp1_o  = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0};
      expb_o  = '{0, 7, 6, 7};
      expb_tc = '{0, 1, 0, 0};
`endif
      exp1_tc = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
      exp2_o  = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3};

      // Two reset cycles, then check the reset state.
      repeat (2) @(negedge c);
      checkOutput("reset_o0", 32'(if0.o), 7);
      checkOutput("reset_tc0", 32'(if0.tc), 0);
      checkOutput("reset_o1", 32'(if1.o), 0);
      checkOutput("reset_o2", 32'(if2.o), 0);

      // Free-running sequences.
      r = 1'b0;
      applyStimulus(0, 1'b1, DIR_DOWN, 1'b0, 0);
      applyStimulus(1, 1'b1, DIR_UP, 1'b0, 0);
      applyStimulus(2, 1'b1, DIR_UP, 1'b0, 0);
      for (int k = 0; k < 10; k++) begin
         @(negedge c);
         checkOutput("down_seq_o0", 32'(if0.o), exp0_o[k]);
         checkOutput("down_seq_tc0", 32'(if0.tc), exp0_tc[k]);
         checkOutput("mod10_seq_o1", 32'(if1.o), exp1_o[k]);
         checkOutput("mod10_seq_tc1", 32'(if1.tc), exp1_tc[k]);
         checkOutput("ps3_seq_o2", 32'(if2.o), exp2_o[k]);
      end

      // Clamped load, load over tick, prescaler freeze and direction flip.
      applyStimulus(0, 1'b0, DIR_DOWN, 1'b0, 0);
      applyStimulus(1, 1'b0, DIR_UP, 1'b1, 13);
      applyStimulus(2, 1'b0, DIR_UP, 1'b0, 0);
      @(negedge c);
      checkOutput("clamp_o1", 32'(if1.o), 9);
      checkOutput("hold_o0", 32'(if0.o), exp0_o[9]);
      checkOutput("freeze_o2", 32'(if2.o), 3);
      applyStimulus(1, 1'b1, DIR_UP, 1'b1, 3);
      @(negedge c);
      checkOutput("ld_over_tick_o1", 32'(if1.o), 3);
      checkOutput("ld_over_tick_tc1", 32'(if1.tc), 0);
      checkOutput("freeze_o2", 32'(if2.o), 3);
      applyStimulus(1, 1'b0, DIR_UP, 1'b0, 0);
      repeat (3) begin
         @(negedge c);
         checkOutput("freeze_o2", 32'(if2.o), 3);
         checkOutput("hold_o1", 32'(if1.o), 3);
      end
      applyStimulus(2, 1'b1, DIR_UP, 1'b0, 0);
      @(negedge c);
      checkOutput("phase_o2", 32'(if2.o), 3);
      applyStimulus(2, 1'b1, DIR_DOWN, 1'b0, 0);
      @(negedge c);
      checkOutput("dir_flip_o2", 32'(if2.o), 2);
      checkOutput("dir_flip_tc2", 32'(if2.tc), 0);

      // Reset in the middle of counting.
      applyStimulus(1, 1'b1, DIR_UP, 1'b0, 0);
      applyStimulus(2, 1'b1, DIR_UP, 1'b0, 0);
      repeat (2) @(negedge c);
      checkOutput("pre_reset_o1", 32'(if1.o), 5);
      r = 1'b1;
      @(negedge c);
      r = 1'b0;
      checkOutput("mid_reset_o1", 32'(if1.o), 0);
      checkOutput("mid_reset_tc1", 32'(if1.tc), 0);
      checkOutput("mid_reset_o2", 32'(if2.o), 0);
      checkOutput("mid_reset_o0", 32'(if0.o), 7);
      for (int k = 0; k < 3; k++) begin
         @(negedge c);
         checkOutput("rst_interval_o2", 32'(if2.o), (k == 2) ? 1 : 0);
      end

      // Boundary behaviour of the default counter from o = 1 counting down.
      applyStimulus(0, 1'b0, DIR_DOWN, 1'b1, 1);
      @(negedge c);
      checkOutput("load1_o0", 32'(if0.o), 1);
      applyStimulus(0, 1'b1, DIR_DOWN, 1'b0, 0);
      for (int k = 0; k < 4; k++) begin
         @(negedge c);
         checkOutput("boundary_o0", 32'(if0.o), expb_o[k]);
         checkOutput("boundary_tc0", 32'(if0.tc), expb_tc[k]);
         if (k == 2) applyStimulus(0, 1'b1, DIR_UP, 1'b0, 0);
      end

      // Randomized phase, checked by the model every cycle.
      for (int n = 0; n < 3000; n++) begin
         @(negedge c);
         r = ($urandom_range(0, 99) == 0);
         for (int i = 0; i < 3; i++) begin
            applyStimulus(i, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                          $urandom_range(0, 11) == 0, int'($urandom_range(0, (i == 1) ? 15 : 7)));
         end
      end

      @(negedge c);
      @(negedge c);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
